// File: rtl/layers_mosi_dispatch_if.sv
// Host command stream in and per-layer MOSI byte streams out, grouped for the dispatcher.
// The master side is the host/layer environment; the dispatcher takes the slave side.
interface layers_mosi_dispatch_if #(
    parameter int LAYER_COUNT = 5
) ();
    logic [7:0]               s_axis_tdata;
    logic                     s_axis_tvalid;
    logic                     s_axis_tlast;
    logic                     s_axis_tready;
    logic [LAYER_COUNT*8-1:0] layers_mosi_m_axis_tdata;
    logic [LAYER_COUNT-1:0]   layers_mosi_m_axis_tvalid;
    logic [LAYER_COUNT-1:0]   layers_mosi_m_axis_tlast;
    logic [LAYER_COUNT-1:0]   layers_mosi_m_axis_tready;

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
        input  s_axis_tready,
        input  layers_mosi_m_axis_tdata, layers_mosi_m_axis_tvalid, layers_mosi_m_axis_tlast,
        output layers_mosi_m_axis_tready
    );

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
        output s_axis_tready,
        output layers_mosi_m_axis_tdata, layers_mosi_m_axis_tvalid, layers_mosi_m_axis_tlast,
        input  layers_mosi_m_axis_tready
    );
endinterface

// File: rtl/layers_mosi_dispatch.sv
// Routes framed host commands (HDR | LEN_HI | LEN_LO | payload) to one layer or all layers.
// Payload latency 1 cycle; host is stalled until every selected layer has taken the held byte.
module layers_mosi_dispatch #(
    parameter int         LAYER_COUNT = 5,
    parameter logic [7:0] BCAST_ID    = 8'hFF
) (
    input  logic                   clk_core,
    input  logic                   clk_core_resn,
    input  logic                   cfg_enable,
    layers_mosi_dispatch_if.slave  bus,
    output logic                   status_busy,
    output logic [31:0]            stat_frames_dispatched,
    output logic [15:0]            stat_errors
);
    typedef enum logic [2:0] {
        ST_HDR,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_PAYLOAD,
        ST_DRAIN
    } state_t;

    state_t                 state;
    logic [1:0]             rst_pipe;
    logic                   rst_n;
    logic [LAYER_COUNT-1:0] sel;
    logic [LAYER_COUNT-1:0] hdr_sel;
    logic [LAYER_COUNT-1:0] pending;
    logic [7:0]             len_hi;
    logic [15:0]            len_full;
    logic [15:0]            remaining;
    logic [7:0]             out_dat;
    logic                   out_last;
    logic                   hdr_ok;
    logic                   s_rdy;
    logic                   s_acc;
    logic                   err_inc;
    logic                   frame_inc;

    // Reset asserts asynchronously, releases on a clock edge.
    always_ff @(posedge clk_core or negedge clk_core_resn) begin
        if (!clk_core_resn) begin
            rst_pipe <= 2'b00;
        end else begin
            rst_pipe <= {rst_pipe[0], 1'b1};
        end
    end
    assign rst_n = rst_pipe[1];

    always_comb begin
        hdr_sel = '0;
        for (int i = 0; i < LAYER_COUNT; i++) begin
            if (bus.s_axis_tdata == 8'(i + 1)) begin
                hdr_sel[i] = 1'b1;
            end
        end
        if (bus.s_axis_tdata == BCAST_ID) begin
            hdr_sel = '1;
        end
        hdr_ok = |hdr_sel;
    end

    assign len_full = {len_hi, bus.s_axis_tdata};

    always_comb begin
        s_rdy = 1'b0;
        if (rst_n) begin
            case (state)
                ST_HDR:                        s_rdy = cfg_enable;
                ST_LEN_HI, ST_LEN_LO, ST_DRAIN: s_rdy = 1'b1;
                // Accept when every held byte is gone or leaves on this edge.
                ST_PAYLOAD: s_rdy = ((pending & ~bus.layers_mosi_m_axis_tready) == '0);
                default:                       s_rdy = 1'b0;
            endcase
        end
    end

    assign bus.s_axis_tready = s_rdy;
    assign s_acc             = s_rdy & bus.s_axis_tvalid;

    always_comb begin
        err_inc   = 1'b0;
        frame_inc = 1'b0;
        if (s_acc) begin
            case (state)
                ST_HDR:    err_inc = bus.s_axis_tlast | ~hdr_ok;
                ST_LEN_HI: err_inc = bus.s_axis_tlast;
                ST_LEN_LO: err_inc = bus.s_axis_tlast | (len_full == 16'd0);
                ST_PAYLOAD: begin
                    if (remaining == 16'd1) begin
                        frame_inc = 1'b1;
                        err_inc   = ~bus.s_axis_tlast;
                    end else begin
                        err_inc = bus.s_axis_tlast;
                    end
                end
                default: err_inc = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_core or negedge rst_n) begin
        if (!rst_n) begin
            state                  <= ST_HDR;
            sel                    <= '0;
            pending                <= '0;
            len_hi                 <= 8'd0;
            remaining              <= 16'd0;
            out_dat                <= 8'd0;
            out_last               <= 1'b0;
            stat_frames_dispatched <= 32'd0;
            stat_errors            <= 16'd0;
        end else begin
            if (err_inc && (stat_errors != 16'hFFFF)) begin
                stat_errors <= stat_errors + 16'd1;
            end
            if (frame_inc) begin
                stat_frames_dispatched <= stat_frames_dispatched + 32'd1;
            end
            pending <= pending & ~bus.layers_mosi_m_axis_tready;
            if (s_acc) begin
                case (state)
                    ST_HDR: begin
                        if (bus.s_axis_tlast) begin
                            state <= ST_HDR;
                        end else if (!hdr_ok) begin
                            state <= ST_DRAIN;
                        end else begin
                            sel   <= hdr_sel;
                            state <= ST_LEN_HI;
                        end
                    end
                    ST_LEN_HI: begin
                        if (bus.s_axis_tlast) begin
                            state <= ST_HDR;
                        end else begin
                            len_hi <= bus.s_axis_tdata;
                            state  <= ST_LEN_LO;
                        end
                    end
                    ST_LEN_LO: begin
                        if (bus.s_axis_tlast) begin
                            state <= ST_HDR;
                        end else if (len_full == 16'd0) begin
                            state <= ST_DRAIN;
                        end else begin
                            remaining <= len_full;
                            state     <= ST_PAYLOAD;
                        end
                    end
                    ST_PAYLOAD: begin
                        out_dat   <= bus.s_axis_tdata;
                        pending   <= sel;
                        remaining <= remaining - 16'd1;
                        if (remaining == 16'd1) begin
                            out_last <= 1'b1;
                            state    <= bus.s_axis_tlast ? ST_HDR : ST_DRAIN;
                        end else if (bus.s_axis_tlast) begin
                            out_last <= 1'b1;
                            state    <= ST_HDR;
                        end else begin
                            out_last <= 1'b0;
                        end
                    end
                    ST_DRAIN: begin
                        if (bus.s_axis_tlast) begin
                            state <= ST_HDR;
                        end
                    end
                    default: state <= ST_HDR;
                endcase
            end
        end
    end

    assign bus.layers_mosi_m_axis_tdata  = {LAYER_COUNT{out_dat}};
    assign bus.layers_mosi_m_axis_tvalid = pending;
    assign bus.layers_mosi_m_axis_tlast  = pending & {LAYER_COUNT{out_last}};
    assign status_busy                   = (state != ST_HDR) | (|pending);
endmodule

// File: tb/tb_layers_mosi_dispatch.sv
// Directed and randomized frame streams checked against a frame-level parser of the command format.
module tb_layers_mosi_dispatch;
    localparam int LC = 5;

    logic        clk_core = 1'b0;
    logic        clk_core_resn;
    logic        cfg_enable;
    logic        status_busy;
    logic [31:0] frames;
    logic [15:0] errors;

    always #5 clk_core = ~clk_core;

    layers_mosi_dispatch_if #(.LAYER_COUNT(LC)) bus ();

    layers_mosi_dispatch #(.LAYER_COUNT(LC), .BCAST_ID(8'hFF)) dut (
        .clk_core               (clk_core),
        .clk_core_resn          (clk_core_resn),
        .cfg_enable             (cfg_enable),
        .bus                    (bus),
        .status_busy            (status_busy),
        .stat_frames_dispatched (frames),
        .stat_errors            (errors)
    );

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] sd[$];
    bit         sl[$];
    logic [8:0] exp_q[LC][$];
    logic [8:0] got_q[LC][$];
    int         exp_frames  = 0;
    int         exp_errors  = 0;
    int         rdy_pct     = 100;
    int         hold0       = 0;
    int         cfg_drop_at = -1;
    bit         blk_chk     = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Drive layer readies, sample just before the rising edge, return at the next falling edge.
    task automatic tick(output bit acc);
        for (int i = 0; i < LC; i++) begin
            bus.layers_mosi_m_axis_tready[i] = ($urandom_range(99) < rdy_pct);
        end
        if (hold0 > 0) begin
            bus.layers_mosi_m_axis_tready[0] = 1'b0;
            hold0--;
        end
        #3;
        for (int i = 0; i < LC; i++) begin
            if (bus.layers_mosi_m_axis_tvalid[i] && bus.layers_mosi_m_axis_tready[i]) begin
                got_q[i].push_back({bus.layers_mosi_m_axis_tlast[i], bus.layers_mosi_m_axis_tdata[i*8 +: 8]});
            end
        end
        if (blk_chk && bus.s_axis_tvalid && bus.layers_mosi_m_axis_tvalid[0] && !bus.layers_mosi_m_axis_tready[0]) begin
            chk("bcast_hold_s_tready", 32'(bus.s_axis_tready), 32'd0);
        end
        acc = bus.s_axis_tvalid && bus.s_axis_tready;
        @(negedge clk_core);
    endtask

    task automatic put(input logic [7:0] d, input bit l);
        sd.push_back(d);
        sl.push_back(l);
    endtask

    // Payload region is last_pos+1 bytes with tlast on its final byte.
    task automatic add_frame(input logic [7:0] id, input int len, input int last_pos);
        logic [15:0] l16;
        l16 = 16'(len);
        put(id, 1'b0);
        put(l16[15:8], 1'b0);
        put(l16[7:0], 1'b0);
        for (int k = 0; k <= last_pos; k++) begin
            put(8'($urandom_range(255)), k == last_pos);
        end
    endtask

    task automatic bump_err();
        if (exp_errors < 65535) exp_errors++;
    endtask

    function automatic int skip_last(input int i);
        while (i < sd.size()) begin
            if (sl[i]) return i + 1;
            i++;
        end
        return i;
    endfunction

    // Frame-level parse of the queued byte stream into per-layer expected deliveries.
    task automatic model_stream();
        int          i;
        int          n;
        logic [7:0]  h;
        logic [7:0]  d;
        logic [15:0] len;
        bit          ok;
        bit          lst;
        bit          endk;
        i = 0;
        n = sd.size();
        while (i < n) begin
            h  = sd[i];
            ok = ((h >= 8'd1) && (h <= 8'(LC))) || (h == 8'hFF);
            if (sl[i]) begin bump_err(); i++; continue; end
            i++;
            if (!ok) begin bump_err(); i = skip_last(i); continue; end
            if (i >= n) break;
            if (sl[i]) begin bump_err(); i++; continue; end
            len[15:8] = sd[i];
            i++;
            if (i >= n) break;
            if (sl[i]) begin bump_err(); i++; continue; end
            len[7:0] = sd[i];
            i++;
            if (len == 16'd0) begin bump_err(); i = skip_last(i); continue; end
            for (int k = 0; k < int'(len) && i < n; k++) begin
                d    = sd[i];
                lst  = sl[i];
                endk = (k == int'(len) - 1);
                i++;
                for (int l = 0; l < LC; l++) begin
                    if (h == 8'hFF || h == 8'(l + 1)) exp_q[l].push_back({lst | endk, d});
                end
                if (endk) begin
                    exp_frames++;
                    if (!lst) begin bump_err(); i = skip_last(i); end
                    break;
                end
                if (lst) begin bump_err(); break; end
            end
        end
    endtask

    task automatic send_stream(input int max_acc, input int gap_pct);
        int j;
        int cyc;
        bit acc;
        j   = 0;
        cyc = 0;
        while (j < sd.size() && j < max_acc) begin
            if (!bus.s_axis_tvalid) begin
                if ($urandom_range(99) < gap_pct) begin
                    bus.s_axis_tvalid = 1'b0;
                end else begin
                    bus.s_axis_tvalid = 1'b1;
                    bus.s_axis_tdata  = sd[j];
                    bus.s_axis_tlast  = sl[j];
                end
            end
            tick(acc);
            if (acc) begin
                j++;
                bus.s_axis_tvalid = 1'b0;
                if (j == cfg_drop_at) cfg_enable = 1'b0;
            end
            cyc++;
            if (cyc > 5000) begin
                chk("stream_timeout", 32'(j), 32'(sd.size()));
                break;
            end
        end
        bus.s_axis_tvalid = 1'b0;
    endtask

    task automatic drain();
        int cyc;
        bit acc;
        cyc = 0;
        while (status_busy) begin
            tick(acc);
            cyc++;
            if (cyc > 2000) begin
                chk("drain_timeout", 32'(status_busy), 32'd0);
                break;
            end
        end
    endtask

    task automatic compare_layers(input string tag);
        for (int l = 0; l < LC; l++) begin
            chk($sformatf("%s_L%0d_count", tag, l), 32'(got_q[l].size()), 32'(exp_q[l].size()));
            for (int k = 0; k < got_q[l].size() && k < exp_q[l].size(); k++) begin
                chk($sformatf("%s_L%0d_byte%0d", tag, l, k), 32'(got_q[l][k]), 32'(exp_q[l][k]));
            end
            got_q[l].delete();
            exp_q[l].delete();
        end
    endtask

    task automatic run_case(input string tag, input int gap_pct);
        model_stream();
        send_stream(1 << 30, gap_pct);
        drain();
        compare_layers(tag);
        chk({tag, "_frames"}, frames, 32'(exp_frames));
        chk({tag, "_errors"}, 32'(errors), 32'(exp_errors));
        sd.delete();
        sl.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit         acc;
        int         r;
        int         len;
        logic [7:0] id;

        clk_core_resn                 = 1'b0;
        cfg_enable                    = 1'b1;
        bus.s_axis_tvalid             = 1'b0;
        bus.s_axis_tdata              = 8'd0;
        bus.s_axis_tlast              = 1'b0;
        bus.layers_mosi_m_axis_tready = '1;
        @(negedge clk_core);
        repeat (3) tick(acc);

        chk("rst_m_tvalid", 32'(bus.layers_mosi_m_axis_tvalid), 32'd0);
        chk("rst_s_tready", 32'(bus.s_axis_tready), 32'd0);
        chk("rst_busy",     32'(status_busy), 32'd0);
        chk("rst_frames",   frames, 32'd0);
        chk("rst_errors",   32'(errors), 32'd0);
        clk_core_resn = 1'b1;

        // Single-layer frame, all ready.
        rdy_pct = 100;
        put(8'h02, 0); put(8'h00, 0); put(8'h03, 0); put(8'hAA, 0); put(8'hBB, 0); put(8'hCC, 1);
        run_case("t1_layer2", 0);

        // Broadcast while layer 0 is held off.
        hold0   = 9;
        blk_chk = 1'b1;
        put(8'hFF, 0); put(8'h00, 0); put(8'h02, 0); put(8'h11, 0); put(8'h22, 1);
        run_case("t2_bcast", 0);
        blk_chk = 1'b0;

        // Bad header drained, then a good frame.
        rdy_pct = 80;
        put(8'h00, 0); put(8'h00, 0); put(8'h01, 0); put(8'h55, 1);
        put(8'h03, 0); put(8'h00, 0); put(8'h01, 0); put(8'h5A, 1);
        run_case("t3_badhdr", 20);

        // Short frame.
        put(8'h01, 0); put(8'h00, 0); put(8'h04, 0); put(8'hA0, 0); put(8'hA1, 1);
        run_case("t4_short", 10);

        // Overlong frame.
        put(8'h01, 0); put(8'h00, 0); put(8'h01, 0); put(8'h77, 0); put(8'h88, 0); put(8'h99, 1);
        run_case("t5_long", 10);

        // cfg_enable blocks headers only.
        cfg_enable        = 1'b0;
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_tdata  = 8'h03;
        bus.s_axis_tlast  = 1'b0;
        repeat (3) begin
            tick(acc);
            chk("cfg_off_accept", 32'(acc), 32'd0);
        end
        bus.s_axis_tvalid = 1'b0;
        cfg_enable        = 1'b1;
        cfg_drop_at       = 1;
        put(8'h03, 0); put(8'h00, 0); put(8'h02, 0); put(8'hD0, 0); put(8'hD1, 1);
        run_case("t7_cfg_midframe", 0);
        cfg_drop_at       = -1;
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_tdata  = 8'h04;
        repeat (3) begin
            tick(acc);
            chk("cfg_off_after_frame", 32'(acc), 32'd0);
        end
        bus.s_axis_tvalid = 1'b0;
        cfg_enable        = 1'b1;

        // Randomized mix of good and malformed frames.
        rdy_pct = 60;
        for (int f = 0; f < 40; f++) begin
            r = $urandom_range(11);
            if (r <= 5) begin
                len = $urandom_range(1, 6);
                add_frame(8'(r % 5 + 1), len, len - 1);
            end else if (r == 6) begin
                len = $urandom_range(1, 4);
                add_frame(8'hFF, len, len - 1);
            end else if (r == 7) begin
                len = $urandom_range(2, 6);
                add_frame(8'($urandom_range(1, 5)), len, $urandom_range(0, len + 2));
            end else if (r == 8) begin
                add_frame(8'($urandom_range(6, 254)), $urandom_range(0, 4), $urandom_range(0, 3));
            end else if (r == 9) begin
                add_frame(8'($urandom_range(1, 5)), 0, $urandom_range(0, 2));
            end else if (r == 10) begin
                put(8'($urandom_range(1, 5)), 1);
            end else begin
                id = 8'($urandom_range(1, 5));
                put(id, 0); put(8'h00, 0); put(8'h03, 1);
            end
        end
        run_case("t8_random", 30);

        // Reset in the middle of an 8-byte payload.
        rdy_pct = 100;
        add_frame(8'h01, 8, 7);
        send_stream(6, 0);
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_tdata  = sd[6];
        bus.s_axis_tlast  = 1'b0;
        #1;
        chk("pre_rst_m_tvalid0", 32'(bus.layers_mosi_m_axis_tvalid[0]), 32'd1);
        #1;
        clk_core_resn = 1'b0;
        #1;
        chk("mid_rst_m_tvalid", 32'(bus.layers_mosi_m_axis_tvalid), 32'd0);
        chk("mid_rst_s_tready", 32'(bus.s_axis_tready), 32'd0);
        chk("mid_rst_frames",   frames, 32'd0);
        chk("mid_rst_errors",   32'(errors), 32'd0);
        bus.s_axis_tvalid = 1'b0;
        @(negedge clk_core);
        repeat (2) tick(acc);
        clk_core_resn = 1'b1;
        sd.delete();
        sl.delete();
        for (int l = 0; l < LC; l++) begin
            got_q[l].delete();
            exp_q[l].delete();
        end
        exp_frames = 0;
        exp_errors = 0;
        put(8'h05, 0); put(8'h00, 0); put(8'h02, 0); put(8'hE1, 0); put(8'hE2, 1);
        run_case("t6_after_reset", 10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
